// File: rtl/fetch_unit_pkg.sv
// Shared core types for the fetch stage: FSM states, fetch packet layout and reset PC.
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h1eceb000;
    localparam int          FETCH_PKT_WIDTH  = 65;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_pkt_t;

    function automatic fetch_pkt_t make_pkt(input logic [31:0] p_pc, input logic [31:0] p_inst);
        fetch_pkt_t pkt;
        pkt.valid = 1'b1;
        pkt.pc    = p_pc;
        pkt.inst  = p_inst;
        return pkt;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// In-order fetch stage: one outstanding I-mem read, packs {valid, pc, inst} into the
// instruction queue, stalls on queue-full and drops wrong-path responses after a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          PKT_WIDTH = FETCH_PKT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [31:0]          imem_addr,
    output logic [3:0]           imem_rmask,
    input  logic [31:0]          imem_rdata,
    input  logic                 imem_resp,
    input  logic                 iq_full,
    output logic                 iq_enq,
    output logic [PKT_WIDTH-1:0] iq_data,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  hold_q;
    logic [31:0]  imem_addr_q;
    logic [3:0]   imem_rmask_q;
    logic         iq_enq_q;
    fetch_pkt_t   iq_data_q;

    logic [31:0]  pc_inc_d;
    logic [31:0]  redirect_tgt_d;

    assign pc_inc_d       = pc_q + 32'd4;
    assign redirect_tgt_d = redirect_pc & ~32'h3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            hold_q       <= 32'h0;
            imem_addr_q  <= RESET_PC;
            imem_rmask_q <= 4'h0;
            iq_enq_q     <= 1'b0;
            iq_data_q    <= '0;
        end else begin
            // Request and push strobes are single-cycle pulses.
            imem_rmask_q <= 4'h0;
            iq_enq_q     <= 1'b0;

            if (redirect_valid) begin
                pc_q <= redirect_tgt_d;
                // An unanswered request must drain before the new path may issue.
                if ((state_q == WAIT && !imem_resp) || state_q == DISCARD) begin
                    state_q <= DISCARD;
                end else begin
                    imem_addr_q  <= redirect_tgt_d;
                    imem_rmask_q <= 4'hF;
                    state_q      <= WAIT;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        imem_addr_q  <= pc_q;
                        imem_rmask_q <= 4'hF;
                        state_q      <= WAIT;
                    end
                    WAIT: begin
                        if (imem_resp) begin
                            if (!iq_full) begin
                                iq_enq_q     <= 1'b1;
                                iq_data_q    <= make_pkt(pc_q, imem_rdata);
                                imem_addr_q  <= pc_inc_d;
                                imem_rmask_q <= 4'hF;
                                pc_q         <= pc_inc_d;
                            end else begin
                                hold_q  <= imem_rdata;
                                state_q <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (!iq_full) begin
                            iq_enq_q     <= 1'b1;
                            iq_data_q    <= make_pkt(pc_q, hold_q);
                            imem_addr_q  <= pc_inc_d;
                            imem_rmask_q <= 4'hF;
                            pc_q         <= pc_inc_d;
                            state_q      <= WAIT;
                        end
                    end
                    DISCARD: begin
                        // pc_q already holds the redirect target; the returning word is wrong-path.
                        if (imem_resp) begin
                            imem_addr_q  <= pc_q;
                            imem_rmask_q <= 4'hF;
                            state_q      <= WAIT;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign imem_addr  = imem_addr_q;
    assign imem_rmask = imem_rmask_q;
    assign iq_enq     = iq_enq_q;
    assign iq_data    = iq_data_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scenario tasks plus a randomized run against a
// transaction-level model of the fetch stream (sequential PCs, push after first non-full cycle).
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_resp = 1'b0;
    logic        iq_full = 1'b0;
    logic        iq_enq;
    logic [64:0] iq_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .PKT_WIDTH(65)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .iq_full        (iq_full),
        .iq_enq         (iq_enq),
        .iq_data        (iq_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [64:0] obs_pkt[$];
    int          obs_pkt_cyc[$];
    logic [31:0] obs_req[$];
    int          obs_req_cyc[$];
    int          resp_cyc[$];
    bit          full_hist[0:2047];
    int          overlap_cnt, bad_mask_cnt, enq_full_cnt;

    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          mem_lat;
    bit          mem_lat_rand;
    bit          mem_const;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input bit c);
        return c ? 32'h00000013 : ({a[15:0], a[31:16]} ^ 32'hC0DE0013);
    endfunction

    function automatic logic [64:0] exp_pkt(input logic [31:0] pc, input bit c);
        return {1'b1, pc, mem_word(pc, c)};
    endfunction

    task automatic clear_model();
        obs_pkt.delete(); obs_pkt_cyc.delete();
        obs_req.delete(); obs_req_cyc.delete();
        resp_cyc.delete();
        for (int i = 0; i < 2048; i++) full_hist[i] = 1'b0;
        overlap_cnt = 0; bad_mask_cnt = 0; enq_full_cnt = 0;
        mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
        mem_lat_rand = 1'b0; mem_const = 1'b0;
    endtask

    task automatic do_reset(input int lat);
        rst = 1'b1;
        imem_resp = 1'b0; imem_rdata = 32'h0; iq_full = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        clear_model();
        mem_lat = lat;
    endtask

    // Advance one cycle: record what the DUT shows, then play the memory for this cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (cyc < 2048) full_hist[cyc] = iq_full;
        if (iq_enq === 1'b1 && iq_full === 1'b1) enq_full_cnt++;
        cyc++;
        if (iq_enq === 1'b1) begin
            obs_pkt.push_back(iq_data);
            obs_pkt_cyc.push_back(cyc);
        end
        if (imem_rmask === 4'hF) begin
            obs_req.push_back(imem_addr);
            obs_req_cyc.push_back(cyc);
            if (mem_busy) overlap_cnt++;
        end else if (imem_rmask !== 4'h0) begin
            bad_mask_cnt++;
        end
        imem_resp  = 1'b0;
        imem_rdata = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_resp  = 1'b1;
                imem_rdata = mem_word(mem_addr, mem_const);
                mem_busy   = 1'b0;
                resp_cyc.push_back(cyc);
            end
        end
        if (imem_rmask === 4'hF) begin
            mem_busy = 1'b1;
            mem_cnt  = mem_lat_rand ? int'($urandom_range(1, 4)) : mem_lat;
            mem_addr = imem_addr;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (imem_addr !== RST_PC) begin n_bad++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RST_PC); end
        n_cmp++; if (imem_rmask !== 4'h0) begin n_bad++; $display("FAIL reset_rmask: got %h expected 0", imem_rmask); end
        n_cmp++; if (iq_enq !== 1'b0) begin n_bad++; $display("FAIL reset_enq: got %b expected 0", iq_enq); end
        n_cmp++; if (iq_data !== 65'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", iq_data); end
        do_reset(1);
        n_cmp++; if (imem_rmask !== 4'h0) begin n_bad++; $display("FAIL cycle0_rmask: got %h expected 0", imem_rmask); end
        cycle();
        n_cmp++; if (imem_rmask !== 4'hF || imem_addr !== RST_PC) begin n_bad++; $display("FAIL first_req: got mask %h addr %h expected F %h", imem_rmask, imem_addr, RST_PC); end
        $display("test_reset done: %0d compared so far", n_cmp);
    endtask

    task automatic test_stream();
        do_reset(1);
        mem_const = 1'b1;
        while (cyc < 7) cycle();
        n_cmp++;
        if (obs_req.size() < 3 || obs_pkt.size() < 3) begin
            n_bad++; $display("FAIL stream_count: got %0d req %0d pkt expected >=3 each", obs_req.size(), obs_pkt.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (obs_req[i] !== RST_PC + 32'(4 * i) || obs_req_cyc[i] != 1 + 2 * i) begin
                    n_bad++; $display("FAIL stream_req%0d: got %h@%0d expected %h@%0d", i, obs_req[i], obs_req_cyc[i], RST_PC + 32'(4 * i), 1 + 2 * i);
                end
                n_cmp++;
                if (obs_pkt[i] !== exp_pkt(RST_PC + 32'(4 * i), 1'b1) || obs_pkt_cyc[i] != 3 + 2 * i) begin
                    n_bad++; $display("FAIL stream_pkt%0d: got %h@%0d expected %h@%0d", i, obs_pkt[i], obs_pkt_cyc[i], exp_pkt(RST_PC + 32'(4 * i), 1'b1), 3 + 2 * i);
                end
            end
        end
        $display("test_stream done: %0d requests, %0d pushes", obs_req.size(), obs_pkt.size());
    endtask

    task automatic test_full_hold();
        do_reset(1);
        while (cyc < 9) begin
            cycle();
            iq_full = (cyc >= 1 && cyc <= 5);
        end
        iq_full = 1'b0;
        n_cmp++;
        if (obs_pkt.size() < 1 || obs_pkt[0] !== exp_pkt(RST_PC, 1'b0) || obs_pkt_cyc[0] != 7) begin
            n_bad++; $display("FAIL hold_push: got %0d pushes first %h@%0d expected %h@7", obs_pkt.size(), obs_pkt.size() > 0 ? obs_pkt[0] : 65'h0, obs_pkt.size() > 0 ? obs_pkt_cyc[0] : -1, exp_pkt(RST_PC, 1'b0));
        end
        n_cmp++;
        if (obs_req.size() < 2 || obs_req[1] !== RST_PC + 32'd4 || obs_req_cyc[1] != 7) begin
            n_bad++; $display("FAIL hold_req: got %0d reqs second %h@%0d expected %h@7", obs_req.size(), obs_req.size() > 1 ? obs_req[1] : 32'h0, obs_req.size() > 1 ? obs_req_cyc[1] : -1, RST_PC + 32'd4);
        end
        n_cmp++;
        if (enq_full_cnt != 0) begin n_bad++; $display("FAIL hold_enq_while_full: got %0d expected 0", enq_full_cnt); end
        $display("test_full_hold done: %0d pushes", obs_pkt.size());
    endtask

    task automatic test_redirect_discard();
        do_reset(3);
        while (cyc < 10) begin
            cycle();
            redirect_valid = (cyc == 2);
            redirect_pc    = 32'h00001002;
        end
        redirect_valid = 1'b0;
        n_cmp++;
        if (obs_req.size() < 2 || obs_req[1] !== 32'h00001000 || obs_req_cyc[1] != 5) begin
            n_bad++; $display("FAIL discard_req: got %0d reqs second %h@%0d expected 00001000@5", obs_req.size(), obs_req.size() > 1 ? obs_req[1] : 32'h0, obs_req.size() > 1 ? obs_req_cyc[1] : -1);
        end
        n_cmp++;
        if (obs_pkt.size() != 1 || obs_pkt[0] !== exp_pkt(32'h00001000, 1'b0) || obs_pkt_cyc[0] != 9) begin
            n_bad++; $display("FAIL discard_pkt: got %0d pushes first %h@%0d expected 1 push %h@9", obs_pkt.size(), obs_pkt.size() > 0 ? obs_pkt[0] : 65'h0, obs_pkt.size() > 0 ? obs_pkt_cyc[0] : -1, exp_pkt(32'h00001000, 1'b0));
        end
        $display("test_redirect_discard done: %0d pushes", obs_pkt.size());
    endtask

    task automatic test_redirect_same_cycle();
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        tgt    = $urandom;
        exp_pc = {tgt[31:2], 2'b00};
        do_reset(1);
        while (cyc < 6) begin
            cycle();
            redirect_valid = (cyc == 2);
            redirect_pc    = tgt;
        end
        redirect_valid = 1'b0;
        n_cmp++;
        if (obs_req.size() < 2 || obs_req[1] !== exp_pc || obs_req_cyc[1] != 3) begin
            n_bad++; $display("FAIL samecyc_req: got %0d reqs second %h@%0d expected %h@3", obs_req.size(), obs_req.size() > 1 ? obs_req[1] : 32'h0, obs_req.size() > 1 ? obs_req_cyc[1] : -1, exp_pc);
        end
        n_cmp++;
        if (obs_pkt.size() < 1 || obs_pkt[0] !== exp_pkt(exp_pc, 1'b0) || obs_pkt_cyc[0] != 5) begin
            n_bad++; $display("FAIL samecyc_pkt: got %0d pushes first %h@%0d expected %h@5", obs_pkt.size(), obs_pkt.size() > 0 ? obs_pkt[0] : 65'h0, obs_pkt.size() > 0 ? obs_pkt_cyc[0] : -1, exp_pkt(exp_pc, 1'b0));
        end
        $display("test_redirect_same_cycle done: target %h", tgt);
    endtask

    task automatic test_wrap();
        do_reset(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFFFFFC;
        while (cyc < 5) begin
            cycle();
            redirect_valid = 1'b0;
        end
        n_cmp++;
        if (obs_req.size() < 2 || obs_req[0] !== 32'hFFFFFFFC || obs_req[1] !== 32'h0 || obs_req_cyc[1] != 3) begin
            n_bad++; $display("FAIL wrap_req: got %0d reqs %h then %h expected FFFFFFFC then 00000000@3", obs_req.size(), obs_req.size() > 0 ? obs_req[0] : 32'h0, obs_req.size() > 1 ? obs_req[1] : 32'h1);
        end
        n_cmp++;
        if (obs_pkt.size() < 1 || obs_pkt[0] !== exp_pkt(32'hFFFFFFFC, 1'b0) || obs_pkt_cyc[0] != 3) begin
            n_bad++; $display("FAIL wrap_pkt: got %h expected %h@3", obs_pkt.size() > 0 ? obs_pkt[0] : 65'h0, exp_pkt(32'hFFFFFFFC, 1'b0));
        end
        $display("test_wrap done: %0d requests", obs_req.size());
    endtask

    task automatic test_reset_midflight();
        do_reset(1);
        while (cyc < 3) cycle();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (imem_addr !== RST_PC || imem_rmask !== 4'h0 || iq_enq !== 1'b0 || iq_data !== 65'h0) begin
            n_bad++; $display("FAIL async_reset: got addr %h mask %h enq %b data %h expected %h 0 0 0", imem_addr, imem_rmask, iq_enq, iq_data, RST_PC);
        end
        imem_resp  = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        clear_model();
        mem_lat = 1;
        imem_resp  = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        while (cyc < 4) cycle();
        n_cmp++;
        if (obs_req.size() < 1 || obs_req[0] !== RST_PC || obs_req_cyc[0] != 1) begin
            n_bad++; $display("FAIL restart_req: got %h@%0d expected %h@1", obs_req.size() > 0 ? obs_req[0] : 32'h0, obs_req.size() > 0 ? obs_req_cyc[0] : -1, RST_PC);
        end
        n_cmp++;
        if (obs_pkt.size() < 1 || obs_pkt[0] !== exp_pkt(RST_PC, 1'b0) || obs_pkt_cyc[0] != 3) begin
            n_bad++; $display("FAIL restart_pkt: got %h@%0d expected %h@3", obs_pkt.size() > 0 ? obs_pkt[0] : 65'h0, obs_pkt.size() > 0 ? obs_pkt_cyc[0] : -1, exp_pkt(RST_PC, 1'b0));
        end
        $display("test_reset_midflight done: %0d pushes after restart", obs_pkt.size());
    endtask

    task automatic test_random();
        logic [31:0] pc;
        int          exp_c;
        int          exp_n;
        do_reset(1);
        mem_lat_rand = 1'b1;
        while (cyc < 300) begin
            cycle();
            iq_full = ($urandom_range(0, 99) < 40);
        end
        iq_full = 1'b0;
        while (cyc < 312) cycle();
        for (int i = 0; i < obs_pkt.size(); i++) begin
            pc = RST_PC + 32'(4 * i);
            n_cmp++;
            if (obs_pkt[i] !== exp_pkt(pc, 1'b0)) begin
                n_bad++; $display("FAIL rand_pkt%0d: got %h expected %h", i, obs_pkt[i], exp_pkt(pc, 1'b0));
            end
            exp_c = -1;
            if (i < resp_cyc.size()) begin
                for (int c = resp_cyc[i]; c < 2048; c++) begin
                    if (!full_hist[c]) begin
                        exp_c = c + 1;
                        break;
                    end
                end
            end
            n_cmp++;
            if (obs_pkt_cyc[i] != exp_c) begin
                n_bad++; $display("FAIL rand_push_time%0d: got cycle %0d expected %0d", i, obs_pkt_cyc[i], exp_c);
            end
        end
        for (int i = 0; i < obs_req.size(); i++) begin
            n_cmp++;
            if (obs_req[i] !== RST_PC + 32'(4 * i)) begin
                n_bad++; $display("FAIL rand_req%0d: got %h expected %h", i, obs_req[i], RST_PC + 32'(4 * i));
            end
            if (i >= 1 && i - 1 < obs_pkt.size()) begin
                n_cmp++;
                if (obs_req_cyc[i] != obs_pkt_cyc[i - 1]) begin
                    n_bad++; $display("FAIL rand_req_time%0d: got cycle %0d expected %0d", i, obs_req_cyc[i], obs_pkt_cyc[i - 1]);
                end
            end
        end
        exp_n = resp_cyc.size();
        if (exp_n > 0 && resp_cyc[exp_n - 1] == cyc) exp_n--;
        n_cmp++;
        if (obs_pkt.size() != exp_n || exp_n < 20) begin
            n_bad++; $display("FAIL rand_push_count: got %0d expected %0d (at least 20)", obs_pkt.size(), exp_n);
        end
        n_cmp++;
        if (overlap_cnt != 0 || bad_mask_cnt != 0 || enq_full_cnt != 0) begin
            n_bad++; $display("FAIL rand_protocol: got overlap %0d badmask %0d enq_full %0d expected 0 0 0", overlap_cnt, bad_mask_cnt, enq_full_cnt);
        end
        $display("test_random done: %0d pushes, %0d requests", obs_pkt.size(), obs_req.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        mem_lat = 1;
        test_reset();
        test_stream();
        test_full_hold();
        test_redirect_discard();
        test_redirect_same_cycle();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
